// File: rtl/culsans_pkg.sv
// Shared types for the culsans transaction limiter: ACE channel structs,
// shared-region rule descriptor and the shared-region address match helper.
package culsans_pkg;

  localparam int unsigned IdWidth        = 4;
  localparam int unsigned AddrWidth      = 64;
  localparam int unsigned DataWidth      = 64;
  localparam int unsigned MaxSharedRules = 4;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;

  localparam addr_t DRAMBase = 64'h0000_0000_8000_0000;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [2:0] snoop;
    logic [1:0] domain;
    logic [1:0] bar;
  } aw_chan_t;

  typedef struct packed {
    data_t                  data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [3:0] snoop;
    logic [1:0] domain;
    logic [1:0] bar;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [3:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
    logic     wack;
    logic     rack;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    logic  valid;
    addr_t base;
    addr_t len;
  } rule_t;

  typedef rule_t [MaxSharedRules-1:0] rule_arr_t;

  typedef enum logic {ST_IDLE, ST_COMMIT} commit_state_e;

  // Subtracting first keeps base+len from overflowing at the top of the map.
  function automatic logic is_shared(input addr_t addr, input rule_arr_t rules);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(MaxSharedRules); i++) begin
      if (rules[i].valid && (addr >= rules[i].base) && ((addr - rules[i].base) < rules[i].len))
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/culsans_txn_counter.sv
// Outstanding-transaction up/down counter with limit (full) flag and an
// underflow pulse for a decrement that arrives while the count is zero.
module culsans_txn_counter #(
  parameter int unsigned Max  = 8,
  parameter int unsigned CntW = $clog2(Max + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc,
  input  logic            dec,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            underflow
);

  logic [CntW-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc && !dec && !full) begin
      count_q <= count_q + CntW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - CntW'(1);
    end
  end

  assign count     = count_q;
  assign full      = (count_q == CntW'(Max));
  assign underflow = dec && !inc && (count_q == '0);

endmodule

// File: rtl/culsans_txn_limiter.sv
// Per-core ACE port guard: limits outstanding AR/AW bursts and holds shared
// reads behind in-flight shared writes. Optional macro: CULSANS_TXN_PERF_EN.
module culsans_txn_limiter
  import culsans_pkg::*;
#(
  parameter int unsigned                    MaxRdTxns     = 8,
  parameter int unsigned                    MaxWrTxns     = 8,
  parameter int unsigned                    NrSharedRules = 1,
  parameter addr_t [NrSharedRules-1:0]      SharedBase    = {DRAMBase + 64'h4_0000},
  parameter addr_t [NrSharedRules-1:0]      SharedLength  = {64'h4_0000},
  parameter type                            req_t         = culsans_pkg::req_t,
  parameter type                            resp_t        = culsans_pkg::resp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  req_t                               slv_req_i,
  output resp_t                              slv_resp_o,
  output req_t                               mst_req_o,
  input  resp_t                              mst_resp_i,
  output logic [$clog2(MaxRdTxns+1)-1:0]     rd_outstanding_o,
  output logic [$clog2(MaxWrTxns+1)-1:0]     wr_outstanding_o,
  output logic                               busy_o,
  output logic                               err_o,
  output logic [31:0]                        ar_stall_cycles_o,
  output logic [31:0]                        aw_stall_cycles_o
);

  localparam int unsigned RdW    = $clog2(MaxRdTxns + 1);
  localparam int unsigned WrW    = $clog2(MaxWrTxns + 1);
  localparam int unsigned NrUsed = (NrSharedRules < MaxSharedRules) ? NrSharedRules : MaxSharedRules;

  rule_arr_t     rules;
  logic          ar_shared, aw_shared;
  logic          ar_block, aw_block;
  logic          ar_commit, aw_commit;
  logic          ar_hs, aw_hs, r_last_hs, b_hs;
  logic          sh_dec;
  logic [RdW-1:0] rd_cnt;
  logic [WrW-1:0] wr_cnt, sh_cnt;
  logic          rd_full, wr_full, sh_full;
  logic          rd_uf, wr_uf, sh_uf;
  logic          err_q;
  logic [2**IdWidth-1:0] sh_tbl_q;
  commit_state_e ar_state_q, ar_state_d, aw_state_q, aw_state_d;

  always_comb begin
    rules = '0;
    for (int i = 0; i < int'(NrUsed); i++) begin
      rules[i].valid = 1'b1;
      rules[i].base  = SharedBase[i];
      rules[i].len   = SharedLength[i];
    end
  end

  assign ar_shared = is_shared(slv_req_i.ar.addr, rules);
  assign aw_shared = is_shared(slv_req_i.aw.addr, rules);

  // sh_cnt never exceeds wr_cnt, so its full flag only ever coincides with wr_full.
  assign ar_block = rd_full || (ar_shared && (sh_cnt != '0));
  assign aw_block = wr_full || sh_full;

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid && (!ar_block || ar_commit);
    mst_req_o.aw_valid  = slv_req_i.aw_valid && (!aw_block || aw_commit);
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && (!ar_block || ar_commit);
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && (!aw_block || aw_commit);
  end

  assign ar_hs     = mst_req_o.ar_valid && mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid && mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
  assign sh_dec    = b_hs && sh_tbl_q[mst_resp_i.b.id];

  culsans_txn_counter #(.Max(MaxRdTxns), .CntW(RdW)) i_rd_cnt (
    .clk_i, .rst_i, .inc(ar_hs), .dec(r_last_hs),
    .count(rd_cnt), .full(rd_full), .underflow(rd_uf)
  );

  culsans_txn_counter #(.Max(MaxWrTxns), .CntW(WrW)) i_wr_cnt (
    .clk_i, .rst_i, .inc(aw_hs), .dec(b_hs),
    .count(wr_cnt), .full(wr_full), .underflow(wr_uf)
  );

  culsans_txn_counter #(.Max(MaxWrTxns), .CntW(WrW)) i_sh_wr_cnt (
    .clk_i, .rst_i, .inc(aw_hs && aw_shared), .dec(sh_dec),
    .count(sh_cnt), .full(sh_full), .underflow(sh_uf)
  );

  // NOTE: this per-ID table is reset like any other state; a stale shared bit
  // surviving reset would later decrement sh_cnt for a non-shared write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_tbl_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (b_hs) sh_tbl_q[mst_resp_i.b.id] <= 1'b0;
      if (aw_hs && aw_shared) sh_tbl_q[slv_req_i.aw.id] <= 1'b1;
      if (rd_uf || wr_uf || sh_uf) err_q <= 1'b1;
    end
  end

  // Commit FSMs: once valid is shown downstream it must stay up until ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_state_q <= ST_IDLE;
      aw_state_q <= ST_IDLE;
    end else begin
      ar_state_q <= ar_state_d;
      aw_state_q <= aw_state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ar_state_d = ar_state_q;
    aw_state_d = aw_state_q;
    case (ar_state_q)
      ST_IDLE:   if (mst_req_o.ar_valid && !mst_resp_i.ar_ready) ar_state_d = ST_COMMIT;
      ST_COMMIT: if (mst_resp_i.ar_ready) ar_state_d = ST_IDLE;
      default:   ar_state_d = ST_IDLE;
    endcase
    case (aw_state_q)
      ST_IDLE:   if (mst_req_o.aw_valid && !mst_resp_i.aw_ready) aw_state_d = ST_COMMIT;
      ST_COMMIT: if (mst_resp_i.aw_ready) aw_state_d = ST_IDLE;
      default:   aw_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ar_commit = (ar_state_q == ST_COMMIT);
    aw_commit = (aw_state_q == ST_COMMIT);
  end

  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;
  assign busy_o           = (rd_cnt != '0) || (wr_cnt != '0);
  assign err_o            = err_q;

`ifdef CULSANS_TXN_PERF_EN
  logic [31:0] ar_stall_q, aw_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_stall_q <= '0;
      aw_stall_q <= '0;
    end else begin
      if (slv_req_i.ar_valid && ar_block && !ar_commit && !(&ar_stall_q))
        ar_stall_q <= ar_stall_q + 32'd1;
      if (slv_req_i.aw_valid && aw_block && !aw_commit && !(&aw_stall_q))
        aw_stall_q <= aw_stall_q + 32'd1;
    end
  end

  assign ar_stall_cycles_o = ar_stall_q;
  assign aw_stall_cycles_o = aw_stall_q;
`else
  assign ar_stall_cycles_o = '0;
  assign aw_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_culsans_txn_limiter.sv
// Directed self-checking bench for culsans_txn_limiter: limits, shared-region
// RAW blocking, commit stability, simultaneous inc/dec, underflow and reset.
module tb_culsans_txn_limiter;
  import culsans_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  req_t        slv_req, mst_req;
  resp_t       slv_resp, mst_resp;
  logic [3:0]  rd_out, wr_out;
  logic        busy, err;
  logic [31:0] ar_stall, aw_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  culsans_txn_limiter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .slv_req_i         (slv_req),
    .slv_resp_o        (slv_resp),
    .mst_req_o         (mst_req),
    .mst_resp_i        (mst_resp),
    .rd_outstanding_o  (rd_out),
    .wr_outstanding_o  (wr_out),
    .busy_o            (busy),
    .err_o             (err),
    .ar_stall_cycles_o (ar_stall),
    .aw_stall_cycles_o (aw_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    rst      = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    check("rst_rd", rd_out, 0);
    check("rst_wr", wr_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ar_stall", ar_stall, 0);
    check("rst_aw_stall", aw_stall, 0);

    // 1: eight reads fill the read budget, ninth waits for one R-last
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    slv_req.r_ready   = 1'b1;
    slv_req.b_ready   = 1'b1;
    slv_req.ar.addr   = 64'h8010_0000;
    slv_req.ar.id     = 4'd1;
    slv_req.ar_valid  = 1'b1;
    #1;
    check("t1_ar_addr_pass", mst_req.ar.addr, 64'h8010_0000);
    for (int i = 0; i < 8; i++) begin
      check("t1_ar_ready", slv_resp.ar_ready, 1);
      cyc();
    end
    check("t1_rd_full", rd_out, 8);
    check("t1_busy", busy, 1);
    #1;
    check("t1_ninth_ready", slv_resp.ar_ready, 0);
    check("t1_ninth_valid", mst_req.ar_valid, 0);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    mst_resp.r.data  = 64'hdead_beef;
    #1;
    check("t1_r_data_pass", slv_resp.r.data, 64'hdead_beef);
    check("t1_blocked_during_r", mst_req.ar_valid, 0);
    cyc();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t1_rd_after_r", rd_out, 7);
    check("t1_ninth_issued", mst_req.ar_valid, 1);
    cyc();
    slv_req.ar_valid = 1'b0;
    check("t1_rd_refull", rd_out, 8);
    mst_resp.r_valid = 1'b1;
    repeat (8) cyc();
    mst_resp.r_valid = 1'b0;
    #1;
    check("t1_rd_drained", rd_out, 0);

    // 2: shared write in flight holds a shared read until its B returns
    slv_req.aw.addr  = 64'h8004_0000;
    slv_req.aw.id    = 4'd3;
    slv_req.aw_valid = 1'b1;
    cyc();
    slv_req.aw_valid = 1'b0;
    #1;
    check("t2_wr_one", wr_out, 1);
    slv_req.ar.addr  = 64'h8004_0010;
    slv_req.ar.id    = 4'd2;
    slv_req.ar_valid = 1'b1;
    #1;
    check("t2_raw_stall", mst_req.ar_valid, 0);
    check("t2_raw_ready", slv_resp.ar_ready, 0);
    cyc();
    check("t2_raw_stall2", mst_req.ar_valid, 0);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd3;
    #1;
    check("t2_stall_during_b", mst_req.ar_valid, 0);
    cyc();
    mst_resp.b_valid = 1'b0;
    #1;
    check("t2_wr_zero", wr_out, 0);
    check("t2_ar_issued", mst_req.ar_valid, 1);
    cyc();
    slv_req.ar_valid = 1'b0;
    check("t2_rd_one", rd_out, 1);
    mst_resp.r_valid = 1'b1;
    cyc();
    mst_resp.r_valid = 1'b0;

    // 3: non-shared read passes while a shared write is pending
    slv_req.aw.addr  = 64'h8004_0100;
    slv_req.aw.id    = 4'd5;
    slv_req.aw_valid = 1'b1;
    cyc();
    slv_req.aw_valid = 1'b0;
    slv_req.ar.addr  = 64'h8010_0000;
    slv_req.ar_valid = 1'b1;
    #1;
    check("t3_ar_no_stall", mst_req.ar_valid, 1);
    check("t3_ar_ready", slv_resp.ar_ready, 1);
    cyc();
    slv_req.ar_valid = 1'b0;
    check("t3_rd_one", rd_out, 1);
    check("t3_wr_one", wr_out, 1);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd5;
    mst_resp.r_valid = 1'b1;
    cyc();
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    check("t3_clean_rd", rd_out, 0);
    check("t3_clean_wr", wr_out, 0);

    // 4: committed shared read stays valid while a shared write lands
    mst_resp.ar_ready = 1'b0;
    slv_req.ar.addr   = 64'h8004_0020;
    slv_req.ar_valid  = 1'b1;
    #1;
    check("t4_issue", mst_req.ar_valid, 1);
    cyc();
    slv_req.aw.addr  = 64'h8004_0040;
    slv_req.aw.id    = 4'd6;
    slv_req.aw_valid = 1'b1;
    cyc();
    slv_req.aw_valid = 1'b0;
    #1;
    check("t4_wr_one", wr_out, 1);
    check("t4_hold", mst_req.ar_valid, 1);
    cyc();
    check("t4_hold2", mst_req.ar_valid, 1);
    mst_resp.ar_ready = 1'b1;
    #1;
    check("t4_ready_in_commit", slv_resp.ar_ready, 1);
    cyc();
    check("t4_rd_one", rd_out, 1);
    check("t4_next_blocked", mst_req.ar_valid, 0);
    slv_req.ar_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd6;
    mst_resp.r_valid = 1'b1;
    cyc();
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    check("t4_clean_rd", rd_out, 0);
    check("t4_clean_wr", wr_out, 0);

    // 5: simultaneous AR and R-last, then a spurious B at wr_cnt 0
    slv_req.ar.addr  = 64'h8010_0000;
    slv_req.ar_valid = 1'b1;
    repeat (3) cyc();
    check("t5_rd_three", rd_out, 3);
    mst_resp.r_valid = 1'b1;
    cyc();
    mst_resp.r_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    check("t5_simul_rd", rd_out, 3);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd7;
    #1;
    check("t5_err_before", err, 0);
    cyc();
    mst_resp.b_valid = 1'b0;
    check("t5_err_set", err, 1);
    check("t5_wr_stays_zero", wr_out, 0);
    check("t5_busy", busy, 1);
    cyc();
    check("t5_err_sticky", err, 1);

`ifndef CULSANS_TXN_PERF_EN
    check("perf_ar_tied", ar_stall, 0);
    check("perf_aw_tied", aw_stall, 0);
`endif

    // 6: reset mid-operation
    slv_req.ar_valid = 1'b1;
    repeat (2) cyc();
    slv_req.ar_valid = 1'b0;
    check("t6_rd_five", rd_out, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_rd_cleared", rd_out, 0);
    check("t6_busy_cleared", busy, 0);
    check("t6_err_cleared", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
